// File: rtl/branch_resolve_queue.sv
// In-order queue pairing BHT predictions with branch outcomes.
// Trains the BHT on resolve and flushes wrong-path entries on a mispredict.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 9,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic [PC_W-1:0]            pred_pc,
    input  logic                       pred_bit,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       upd_valid,
    output logic [PC_W-1:0]            upd_pc,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           total_cnt,
    output logic [CNT_W-1:0]           correct_cnt,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = AW'(0) + (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PC_W-1:0] mem_pc [DEPTH];
    logic            mem_pb [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     occ;

    logic            empty;
    logic            pop;
    logic            mis;
    logic            push;
    logic [PC_W-1:0] head_pc;
    logic            head_pb;
    logic            bad;

    assign empty      = (occ == '0);
    assign pred_ready = (occ != FULL);
    assign occupancy  = occ;
    assign head_pc    = mem_pc[rd_ptr];
    assign head_pb    = mem_pb[rd_ptr];
    assign pop        = res_valid && !empty;
    assign mis        = pop && (head_pb != res_taken);
    // A same-cycle push behind a mispredict is on the wrong path.
    assign push       = pred_valid && pred_ready && !mis;
    assign bad        = (pred_valid && !pred_ready) || (res_valid && empty);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr] <= pred_pc;
            mem_pb[wr_ptr] <= pred_bit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (mis) begin
            rd_ptr <= rd_ptr + 1'b1;
            wr_ptr <= rd_ptr + 1'b1;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_valid  <= 1'b0;
            upd_pc     <= '0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            upd_valid  <= pop;
            mispredict <= mis;
            if (pop) begin
                upd_pc    <= head_pc;
                upd_taken <= res_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_cnt   <= '0;
            correct_cnt <= '0;
            err         <= 1'b0;
        end else begin
            if (pop && total_cnt != CNT_MAX)
                total_cnt <= total_cnt + 1'b1;
            if (pop && !mis && correct_cnt != CNT_MAX)
                correct_cnt <= correct_cnt + 1'b1;
            if (bad)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue.
// Hand-computed expectations, immediate assertions per comparison.
module tb_branch_resolve_queue;

    logic        clk;
    logic        reset;
    logic        pred_valid;
    logic [8:0]  pred_pc;
    logic        pred_bit;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic        upd_valid;
    logic [8:0]  upd_pc;
    logic        upd_taken;
    logic        mispredict;
    logic [3:0]  occupancy;
    logic [31:0] total_cnt;
    logic [31:0] correct_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;

    branch_resolve_queue #(.DEPTH(8), .PC_W(9), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .pred_valid  (pred_valid),
        .pred_pc     (pred_pc),
        .pred_bit    (pred_bit),
        .pred_ready  (pred_ready),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .mispredict  (mispredict),
        .occupancy   (occupancy),
        .total_cnt   (total_cnt),
        .correct_cnt (correct_cnt),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, sample 1ns after the edge, then idle them.
    task automatic cyc(input logic pv, input logic [8:0] pc, input logic pb,
                       input logic rv, input logic rt);
        pred_valid = pv;
        pred_pc    = pc;
        pred_bit   = pb;
        res_valid  = rv;
        res_taken  = rt;
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        pred_valid = 1'b0;
        pred_pc = '0;
        pred_bit = 1'b0;
        res_valid = 1'b0;
        res_taken = 1'b0;
        #3;
        chk("rst_occ", occupancy, 0);
        chk("rst_ready", pred_ready, 1);
        chk("rst_upd", upd_valid, 0);
        chk("rst_total", total_cnt, 0);
        chk("rst_err", err, 0);
        #9 reset = 1'b1;

        // Basic push then correct resolve
        cyc(1, 9'h012, 1, 0, 0);
        chk("t1_occ", occupancy, 1);
        cyc(0, 0, 0, 1, 1);
        chk("t1_uv", upd_valid, 1);
        chk("t1_pc", upd_pc, 9'h012);
        chk("t1_tk", upd_taken, 1);
        chk("t1_mis", mispredict, 0);
        chk("t1_tot", total_cnt, 1);
        chk("t1_cor", correct_cnt, 1);
        chk("t1_occ0", occupancy, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t1_uv_low", upd_valid, 0);
        chk("t1_pc_hold", upd_pc, 9'h012);

        // Fill to full, overflow, then drain in order
        for (int i = 0; i < 8; i++)
            cyc(1, 9'(9'h100 + i), 1'(i), 0, 0);
        chk("f_ready", pred_ready, 0);
        chk("f_occ", occupancy, 8);
        chk("f_err0", err, 0);
        cyc(1, 9'h1FF, 1, 0, 0);
        chk("f_occ9", occupancy, 8);
        chk("f_err1", err, 1);
        // push at full with a pop in the same cycle is still ignored
        cyc(1, 9'h0AA, 1, 1, 0);
        chk("f_pc0", upd_pc, 9'h100);
        chk("f_occ7", occupancy, 7);
        for (int i = 1; i < 8; i++) begin
            cyc(0, 0, 0, 1, 1'(i));
            chk($sformatf("f_pc%0d", i), upd_pc, 32'(9'h100 + i));
            chk($sformatf("f_mis%0d", i), mispredict, 0);
        end
        chk("f_occ_end", occupancy, 0);
        chk("f_tot", total_cnt, 9);
        chk("f_cor", correct_cnt, 9);

        // Reset between edges clears sticky err and counters
        #3 reset = 1'b0;
        #1;
        chk("r1_err", err, 0);
        chk("r1_tot", total_cnt, 0);
        #2 reset = 1'b1;

        // Mispredict flushes younger entries
        cyc(1, 9'h001, 0, 0, 0);
        cyc(1, 9'h002, 1, 0, 0);
        cyc(1, 9'h003, 1, 0, 0);
        chk("m_occ3", occupancy, 3);
        cyc(0, 0, 0, 1, 1);
        chk("m_mis", mispredict, 1);
        chk("m_pc", upd_pc, 9'h001);
        chk("m_tk", upd_taken, 1);
        chk("m_occ", occupancy, 0);
        chk("m_tot", total_cnt, 1);
        chk("m_cor", correct_cnt, 0);
        cyc(0, 0, 0, 0, 0);
        chk("m_mis_low", mispredict, 0);
        chk("m_err", err, 0);

        // Simultaneous push and pop
        cyc(1, 9'h010, 1, 0, 0);
        cyc(1, 9'h011, 1, 0, 0);
        cyc(1, 9'h012, 0, 0, 0);
        cyc(1, 9'h013, 1, 1, 1);
        chk("s_occ3", occupancy, 3);
        chk("s_pc", upd_pc, 9'h010);
        chk("s_mis0", mispredict, 0);
        cyc(1, 9'h014, 1, 1, 0);
        chk("s_mis1", mispredict, 1);
        chk("s_pc2", upd_pc, 9'h011);
        chk("s_occ0", occupancy, 0);
        cyc(1, 9'h020, 1, 0, 0);
        cyc(0, 0, 0, 1, 1);
        chk("s_absent", upd_pc, 9'h020);
        chk("s_tot", total_cnt, 4);
        chk("s_cor", correct_cnt, 2);
        chk("s_err0", err, 0);

        // Resolve on empty queue
        cyc(0, 0, 0, 1, 1);
        chk("e_uv", upd_valid, 0);
        chk("e_err", err, 1);
        chk("e_tot", total_cnt, 4);
        chk("e_cor", correct_cnt, 2);
        // push plus resolve on empty: only the push lands
        cyc(1, 9'h030, 1, 1, 1);
        chk("e_push_occ", occupancy, 1);
        chk("e_push_uv", upd_valid, 0);
        cyc(0, 0, 0, 1, 1);
        chk("e_pop_pc", upd_pc, 9'h030);
        chk("e_pop_tot", total_cnt, 5);

        // Reset mid-operation with 5 entries in flight
        for (int i = 0; i < 5; i++)
            cyc(1, 9'(9'h040 + i), 1, 0, 0);
        chk("x_occ5", occupancy, 5);
        #3 reset = 1'b0;
        #1;
        chk("x_occ", occupancy, 0);
        chk("x_ready", pred_ready, 1);
        chk("x_uv", upd_valid, 0);
        chk("x_pc", upd_pc, 0);
        chk("x_tk", upd_taken, 0);
        chk("x_tot", total_cnt, 0);
        chk("x_cor", correct_cnt, 0);
        chk("x_err", err, 0);
        #2 reset = 1'b1;
        cyc(0, 0, 0, 1, 1);
        chk("x_no_upd", upd_valid, 0);
        chk("x_err1", err, 1);
        cyc(0, 0, 0, 0, 0);
        chk("x_no_upd2", upd_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
